// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port synchronous memory between the instruction-fetch
// port and the data port. Data has priority; a pending fetch wins once the data port
// has been granted MAX_DATA_BURST times in a row without an intervening fetch grant.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned MAX_DATA_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned   CntW   = $clog2(MAX_DATA_BURST + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_DATA_BURST);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic              owner_dm_q, owner_dm_d;  // 1: data port owns the access
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [DATA_W-1:0] if_hold_q, if_hold_d;
    logic [DATA_W-1:0] dm_hold_q, dm_hold_d;

    logic req_if, req_dm;
    logic grant_if, grant_dm;
    logic arb_en;

    // Arbitration; in RESP the finishing owner's request is still its old one, so mask it.
    always_comb begin
        req_if = if_req;
        req_dm = dm_req;
        if (state_q == StResp) begin
            if (owner_dm_q) begin
                req_dm = 1'b0;
            end else begin
                req_if = 1'b0;
            end
        end
        grant_dm = req_dm && !(req_if && (count_q >= CntMax));
        grant_if = req_if && !grant_dm;
        arb_en   = (state_q == StIdle) || (state_q == StResp);
    end

    // Next-state, request capture, read-data capture and burst counting.
    always_comb begin
        state_d    = state_q;
        owner_dm_d = owner_dm_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        count_d    = count_q;
        if_hold_d  = if_hold_q;
        dm_hold_d  = dm_hold_q;

        case (state_q)
            StIdle: begin
                state_d = StIdle;
            end
            StAccess: begin
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
                if (!owner_dm_q) begin
                    if_hold_d = mem_rdata;
                end else if (!we_q) begin
                    dm_hold_d = mem_rdata;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (arb_en && (grant_dm || grant_if)) begin
            state_d    = StAccess;
            owner_dm_d = grant_dm;
            if (grant_dm) begin
                addr_d  = dm_addr;
                wdata_d = dm_wdata;
                we_d    = dm_we;
                if (count_q != CntMax) begin
                    count_d = count_q + CntW'(1);
                end
            end else begin
                // Fetches never write; mem_wdata keeps the last issued value.
                addr_d  = if_addr;
                we_d    = 1'b0;
                count_d = '0;
            end
        end
    end

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            owner_dm_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            count_q    <= '0;
            if_hold_q  <= '0;
            dm_hold_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_dm_q <= owner_dm_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            count_q    <= count_d;
            if_hold_q  <= if_hold_d;
            dm_hold_q  <= dm_hold_d;
        end
    end

    // Outputs; mem_wen is decoded from state so an asserted reset kills a write at once.
    always_comb begin
        mem_wen   = (state_q == StAccess) && owner_dm_q && we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        busy      = (state_q != StIdle);
        if_ready  = (state_q == StResp) && !owner_dm_q;
        dm_ready  = (state_q == StResp) && owner_dm_q;
        if_rdata  = if_ready ? mem_rdata : if_hold_q;
        dm_rdata  = (dm_ready && !we_q) ? mem_rdata : dm_hold_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    // Backdoor preload port into the memory model
    logic        bd_we;
    logic [7:0]  bd_addr;
    logic [31:0] bd_data;

    logic [31:0] mem [0:255];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .MAX_DATA_BURST (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Single-port memory: synchronous write, read data one cycle after the address.
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (mem_wen) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b0;
        if_req   = 1'b0;
        if_addr  = '0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        bd_we    = 1'b1;
        bd_addr  = 8'h10;
        bd_data  = 32'h0050_0293;
        tick();
        bd_addr  = 8'h40;
        bd_data  = 32'h0000_1234;
        tick();
        bd_we    = 1'b0;

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_wen", mem_wen, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_dm_ready", dm_ready, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        rst = 1'b1;

        // Single fetch
        if_req  = 1'b1;
        if_addr = 32'h10;
        tick();
        chk("f_acc_busy", busy, 1);
        chk("f_acc_ready", if_ready, 0);
        chk("f_acc_wen", mem_wen, 0);
        chk("f_acc_addr", mem_addr, 32'h10);
        tick();
        chk("f_resp_ready", if_ready, 1);
        chk("f_resp_rdata", if_rdata, 32'h0050_0293);
        chk("f_resp_dm_ready", dm_ready, 0);
        chk("f_resp_wen", mem_wen, 0);
        if_req = 1'b0;
        tick();
        chk("f_idle_ready", if_ready, 0);
        chk("f_idle_busy", busy, 0);
        chk("f_idle_rdata", if_rdata, 32'h0050_0293);

        // Data write then read
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h4;
        dm_wdata = 32'h7;
        tick();
        chk("w_acc_wen", mem_wen, 1);
        chk("w_acc_addr", mem_addr, 32'h4);
        chk("w_acc_wdata", mem_wdata, 32'h7);
        chk("w_acc_ready", dm_ready, 0);
        tick();
        chk("w_resp_wen", mem_wen, 0);
        chk("w_resp_ready", dm_ready, 1);
        chk("w_resp_rdata", dm_rdata, 0);
        dm_req = 1'b0;
        dm_we  = 1'b0;
        tick();
        chk("w_mem", mem[8'h04], 32'h7);
        chk("w_idle_ready", dm_ready, 0);
        dm_req = 1'b1;
        tick();
        chk("r_acc_wen", mem_wen, 0);
        chk("r_acc_addr", mem_addr, 32'h4);
        tick();
        chk("r_resp_ready", dm_ready, 1);
        chk("r_resp_rdata", dm_rdata, 32'h7);
        dm_req = 1'b0;
        tick();
        chk("r_hold_dm", dm_rdata, 32'h7);
        chk("r_hold_if", if_rdata, 32'h0050_0293);

        // Simultaneous requests: data first, fetch back-to-back
        if_req  = 1'b1;
        if_addr = 32'h10;
        dm_req  = 1'b1;
        dm_addr = 32'h4;
        tick();
        chk("s_acc1_addr", mem_addr, 32'h4);
        tick();
        chk("s_resp1_dm", dm_ready, 1);
        chk("s_resp1_if", if_ready, 0);
        chk("s_resp1_rdata", dm_rdata, 32'h7);
        dm_req = 1'b0;
        tick();
        chk("s_acc2_busy", busy, 1);
        chk("s_acc2_addr", mem_addr, 32'h10);
        chk("s_acc2_dm", dm_ready, 0);
        tick();
        chk("s_resp2_if", if_ready, 1);
        chk("s_resp2_rdata", if_rdata, 32'h0050_0293);
        if_req = 1'b0;
        tick();
        chk("s_idle_busy", busy, 0);

        // Starvation: four data grants saturate the counter, then a fetch wins
        dm_req = 1'b1;
        dm_we  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dm_addr  = 32'h20 + 32'(i);
            dm_wdata = 32'h100 + 32'(i);
            tick();
            chk("b_acc_wen", mem_wen, 1);
            chk("b_acc_addr", mem_addr, 32'h20 + 32'(i));
            tick();
            chk("b_resp_dm", dm_ready, 1);
            tick();
            chk("b_idle_busy", busy, 0);
        end
        if_req   = 1'b1;
        if_addr  = 32'h10;
        dm_addr  = 32'h30;
        dm_wdata = 32'h55;
        tick();
        chk("b_fetch_addr", mem_addr, 32'h10);
        chk("b_fetch_wen", mem_wen, 0);
        tick();
        chk("b_fetch_ready", if_ready, 1);
        chk("b_fetch_dm", dm_ready, 0);
        if_req = 1'b0;
        tick();
        chk("b_resume_wen", mem_wen, 1);
        chk("b_resume_addr", mem_addr, 32'h30);
        chk("b_resume_busy", busy, 1);
        tick();
        chk("b_resume_dm", dm_ready, 1);
        dm_req = 1'b0;
        dm_we  = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("b_mem", mem[8'h20 + 8'(i)], 32'h100 + 32'(i));
        end
        // Counter was cleared by the fetch grant: data wins a tie again
        if_req = 1'b1;
        dm_req = 1'b1;
        tick();
        chk("c_acc_addr", mem_addr, 32'h30);
        tick();
        chk("c_resp_dm", dm_ready, 1);
        chk("c_resp_rdata", dm_rdata, 32'h55);
        dm_req = 1'b0;
        tick();
        chk("c_acc2_addr", mem_addr, 32'h10);
        tick();
        chk("c_resp2_if", if_ready, 1);
        if_req = 1'b0;
        tick();

        // Reset in the ACCESS cycle of a write
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h40;
        dm_wdata = 32'hdead;
        if_req   = 1'b1;
        tick();
        chk("x_acc_wen", mem_wen, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("x_rst_wen", mem_wen, 0);
        chk("x_rst_busy", busy, 0);
        chk("x_rst_dm", dm_ready, 0);
        chk("x_rst_if", if_ready, 0);
        chk("x_rst_addr", mem_addr, 0);
        tick();
        chk("x_mem_kept", mem[8'h40], 32'h1234);
        chk("x_hold_busy", busy, 0);
        chk("x_hold_dm", dm_ready, 0);
        chk("x_if_rdata", if_rdata, 0);
        rst = 1'b1;
        tick();
        chk("x_re_wen", mem_wen, 1);
        chk("x_re_addr", mem_addr, 32'h40);
        tick();
        chk("x_re_dm", dm_ready, 1);
        chk("x_re_rdata", dm_rdata, 0);
        dm_req = 1'b0;
        dm_we  = 1'b0;
        tick();
        chk("x_f_addr", mem_addr, 32'h10);
        tick();
        chk("x_f_ready", if_ready, 1);
        chk("x_f_rdata", if_rdata, 32'h0050_0293);
        if_req = 1'b0;
        tick();
        chk("x_mem_new", mem[8'h40], 32'hdead);

        // Ten idle cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("i_busy", busy, 0);
            chk("i_wen", mem_wen, 0);
            chk("i_if_rdata", if_rdata, 32'h0050_0293);
            chk("i_dm_rdata", dm_rdata, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous memory (sync write, one-cycle sync read) between the CPU's instruction-fetch port and its data (MEM-stage) port, so program and data can live in one unified memory. Fixed data-over-fetch priority plus an anti-starvation counter. A low ready on either side is the CPU stall condition. Sits between Top and a single mem instance.

Parameters:
ADDR_W, 32, address width passed unchanged to memory
DATA_W, 32, data width
MAX_DATA_BURST, 4, consecutive data grants after which a pending fetch wins (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
if_req  in  1  fetch request
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched instruction
if_ready  out  1  one-cycle completion pulse for fetch
dm_req  in  1  data request
dm_we  in  1  1=write, 0=read
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  write data
dm_rdata  out  DATA_W  load data
dm_ready  out  1  one-cycle completion pulse for data
mem_wen  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid cycle after address issued
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state IDLE, mem_wen=0, mem_addr=0, mem_wdata=0, if_ready=dm_ready=0, if_rdata/dm_rdata hold regs=0, burst count=0, busy=0. Takes effect immediately; in-flight access dropped, no ready pulse; an ACCESS-cycle write is cancelled since mem_wen drops at once.
- Handshake: requester holds req/addr/we/wdata stable from assertion through the cycle its ready=1. req still high in the cycle after ready = new request.
- States: IDLE, ACCESS, RESP.
- IDLE: arbitrate; on winner, register addr/wdata/we/owner, go ACCESS; else stay.
- ACCESS: mem_addr/mem_wdata from regs; mem_wen=1 only if owner=data and we=1. Always -> RESP.
- RESP: owner's ready=1 for exactly this cycle. Read: owner's rdata output = mem_rdata (combinational route) and captured into owner's hold reg at the edge. Write: dm_rdata keeps hold value. Arbitrate again with current owner's req masked: winner -> ACCESS (back-to-back), none -> IDLE.
- Outside RESP, if_rdata/dm_rdata show hold regs; non-owner's hold reg never changes.
- Arbitration: data wins, unless if_req=1 and count>=MAX_DATA_BURST, then fetch wins. count +1 (saturating at MAX_DATA_BURST) per data grant; cleared to 0 on fetch grant.
- Latency: req sampled at edge k in IDLE -> ACCESS cycle k+1 -> ready in cycle k+2. Back-to-back accesses every 2 cycles.
- mem_addr/mem_wdata registered, hold last issued value when not in ACCESS; mem_wen=0 outside ACCESS.
- Addresses not translated or checked; any ADDR_W value passed through.

Test Plan:
- Single fetch: mem[0x10]=0x00500293, if_req with if_addr=0x10 at edge 0 -> if_ready=1 only in cycle 2, if_rdata=0x00500293 in cycle 2 and held after; mem_wen never 1.
- Data write then read: dm_we=1, dm_addr=0x4, dm_wdata=0x7 -> mem_wen=1 exactly one cycle with mem_addr=0x4, mem_wdata=0x7; dm_ready next cycle; subsequent read of 0x4 returns dm_rdata=0x7.
- Simultaneous requests from IDLE -> data served first (dm_ready cycle 2), fetch back-to-back (if_ready cycle 4), no IDLE cycle between.
- Starvation: MAX_DATA_BURST=4, dm_req held high with new address each grant, if_req high -> exactly 4 dm_ready pulses, then if_ready, then data resumes; count observed 0 after fetch grant.
- Reset during ACCESS of a write: rst=0 mid-cycle -> mem_wen falls immediately, busy=0, no ready pulses, target word unchanged; after release, held requests re-arbitrated from IDLE with count=0.
- No requests for 10 cycles -> busy=0, mem_wen=0, if_rdata/dm_rdata unchanged.
